// File: rtl/muldiv_unit_if.sv
// Handshake and result bus between the pipeline and the multiply/divide unit.
// The pipeline side uses the master modport; the unit uses the slave modport.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        write_hi;
    logic        write_lo;
    logic [31:0] hi_data_out;
    logic [31:0] lo_data_out;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  busy, done, write_hi, write_lo, hi_data_out, lo_data_out
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output busy, done, write_hi, write_lo, hi_data_out, lo_data_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the HI/LO register pair.
// op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
// Multiply takes one MUL cycle; divide is a 32-step restoring divider on
// operand magnitudes, with sign correction applied on the last step.
module muldiv_unit (
    input  logic          clock,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        signed_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] quo_reg;
    logic [31:0] rem_reg;
    logic [4:0]  count_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        accept;
    logic        busy_int;
    logic        done_int;

    logic [63:0] mul_ext_a;
    logic [63:0] mul_ext_b;
    logic [63:0] product;

    logic [31:0] div_divisor;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] step_rem;
    logic [31:0] step_quo;
    logic        quo_neg;
    logic        rem_neg;
    logic [31:0] final_hi;
    logic [31:0] final_lo;

    assign accept = (state == IDLE) && bus.start && !bus.cancel;

    // Sign-extending both operands to 64 bits makes the low 64 bits of an
    // ordinary unsigned product correct for both MULT and MULTU.
    assign mul_ext_a = {{32{signed_reg & a_reg[31]}}, a_reg};
    assign mul_ext_b = {{32{signed_reg & b_reg[31]}}, b_reg};
    assign product   = mul_ext_a * mul_ext_b;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor magnitude when it fits.
    assign div_divisor = (signed_reg && b_reg[31]) ? (~b_reg + 32'd1) : b_reg;
    assign rem_shift   = {rem_reg, quo_reg[31]};
    assign rem_ge      = (rem_shift >= {1'b0, div_divisor});
    assign step_rem    = rem_shift[31:0] - (rem_ge ? div_divisor : 32'd0);
    assign step_quo    = {quo_reg[30:0], rem_ge};

    // Sign fix-up for DIV; a zero divisor bypasses it and returns the raw dividend.
    assign quo_neg  = signed_reg & (a_reg[31] ^ b_reg[31]);
    assign rem_neg  = signed_reg & a_reg[31];
    assign final_lo = (b_reg == 32'd0) ? 32'hFFFF_FFFF
                    : (quo_neg ? (~step_quo + 32'd1) : step_quo);
    assign final_hi = (b_reg == 32'd0) ? a_reg
                    : (rem_neg ? (~step_rem + 32'd1) : step_rem);

    // State register; reset drops any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and strobes; cancel aborts work and masks the DONE strobes.
    always_comb begin
        next_state = state;
        busy_int   = (state != IDLE);
        done_int   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    next_state = bus.op[1] ? DIV : MUL;
                end
            end
            MUL: begin
                next_state = bus.cancel ? IDLE : DONE;
            end
            DIV: begin
                if (bus.cancel) begin
                    next_state = IDLE;
                end else if (count_reg == 5'd31) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
                done_int   = !bus.cancel;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture, divider iteration and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            signed_reg <= 1'b0;
            a_reg      <= 32'd0;
            b_reg      <= 32'd0;
            quo_reg    <= 32'd0;
            rem_reg    <= 32'd0;
            count_reg  <= 5'd0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
        end else begin
            if (accept) begin
                signed_reg <= ~bus.op[0];
                a_reg      <= bus.src_a;
                b_reg      <= bus.src_b;
                quo_reg    <= (!bus.op[0] && bus.src_a[31]) ? (~bus.src_a + 32'd1) : bus.src_a;
                rem_reg    <= 32'd0;
                count_reg  <= 5'd0;
            end
            if (state == MUL && !bus.cancel) begin
                hi_reg <= product[63:32];
                lo_reg <= product[31:0];
            end
            if (state == DIV && !bus.cancel) begin
                quo_reg   <= step_quo;
                rem_reg   <= step_rem;
                count_reg <= count_reg + 5'd1;
                if (count_reg == 5'd31) begin
                    hi_reg <= final_hi;
                    lo_reg <= final_lo;
                end
            end
        end
    end

    assign bus.busy        = busy_int;
    assign bus.done        = done_int;
    assign bus.write_hi    = done_int;
    assign bus.write_lo    = done_int;
    assign bus.hi_data_out = hi_reg;
    assign bus.lo_data_out = lo_reg;

endmodule
